// File: rtl/byte_lane_arbiter_pkg.sv
// Shared types and widths for the round-robin 32:8 byte-lane arbiter.
package byte_lane_arbiter_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned CNT_W          = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/byte_lane_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [REQ_W-1:0]   gnt_idx,
  output logic               any
);

  logic [REQ_W-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sel     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      sel = REQ_W'((32'(ptr) + off) % NUM_REQ);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/byte_lane_arbiter.sv
// Round-robin scheduler serialising one 32-bit word per grant onto an 8-bit lane, MSB first.
module byte_lane_arbiter
  import byte_lane_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = 2
) (
  input  logic                      clk_4f,
  input  logic                      reset_L,
  input  logic [NUM_REQ-1:0]        valid_in,
  input  logic [WORD_W*NUM_REQ-1:0] data_in,
  input  logic                      stall,
  output logic [NUM_REQ-1:0]        ready_out,
  output logic [BYTE_W-1:0]         data_out,
  output logic                      valid_out,
  output logic [REQ_W-1:0]          grant_id,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [REQ_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BYTE_W-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic [REQ_W-1:0]    grant_id_q, grant_id_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [REQ_W-1:0]    gnt_idx;
  logic                any_req;
  logic                slot_open;
  logic                accept;
  logic [WORD_W-1:0]   words [NUM_REQ];
  logic [WORD_W-1:0]   win_word;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = data_in[WORD_W*i +: WORD_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr_arbiter (
    .req     (valid_in),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  // A new word may enter when the lane is empty or its last byte is leaving.
  assign slot_open = !stall && ((state_q == ST_IDLE) || (byte_cnt_q == LAST_BYTE));
  assign accept    = slot_open && any_req;
  assign ready_out = accept ? gnt : '0;
  assign win_word  = words[gnt_idx];

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    rr_ptr_d    = rr_ptr_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    grant_id_d  = grant_id_q;

    if (!stall) begin
      if (accept) begin
        state_d     = ST_SEND;
        byte_cnt_d  = '0;
        shift_d     = {win_word[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
        data_out_d  = win_word[WORD_W-1 -: BYTE_W];
        valid_out_d = 1'b1;
        grant_id_d  = gnt_idx;
        rr_ptr_d    = gnt_idx;
      end else if (state_q == ST_SEND) begin
        if (byte_cnt_q == LAST_BYTE) begin
          state_d     = ST_IDLE;
          byte_cnt_d  = '0;
          data_out_d  = '0;
          valid_out_d = 1'b0;
        end else begin
          byte_cnt_d  = byte_cnt_q + CNT_W'(1);
          shift_d     = {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
          data_out_d  = shift_q[WORD_W-1 -: BYTE_W];
          valid_out_d = 1'b1;
        end
      end
    end

    busy_d = (state_d == ST_SEND);
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      rr_ptr_q    <= REQ_W'(NUM_REQ - 1);
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      rr_ptr_q    <= rr_ptr_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Directed self-checking bench for byte_lane_arbiter with hand-computed expectations.
module tb_byte_lane_arbiter;

  logic         clk_4f;
  logic         reset_L;
  logic [3:0]   valid_in;
  logic [127:0] data_in;
  logic         stall;
  logic [3:0]   ready_out;
  logic [7:0]   data_out;
  logic         valid_out;
  logic [1:0]   grant_id;
  logic         busy;

  int checks;
  int errors;

  byte_lane_arbiter #(.NUM_REQ(4), .REQ_W(2)) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .stall     (stall),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    data_in[32*idx +: 32] = w;
  endtask

  task automatic check_lane(input string tag, input logic [7:0] d, input logic v, input logic [1:0] g);
    check({tag, "_data"}, 32'(data_out), 32'(d));
    check({tag, "_valid"}, 32'(valid_out), 32'(v));
    if (v) check({tag, "_gid"}, 32'(grant_id), 32'(g));
  endtask

  logic [31:0] words3 [4];
  logic [31:0] w;

  initial begin
    checks   = 0;
    errors   = 0;
    reset_L  = 1'b0;
    valid_in = '0;
    data_in  = '0;
    stall    = 1'b0;
    words3[0] = 32'h11223344;
    words3[1] = 32'h55667788;
    words3[2] = 32'h99AABBCC;
    words3[3] = 32'hDDEEFF00;

    // 1: reset values; with all four requesting, requester 0 is offered first
    #1;
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_gid", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(ready_out), 32'h0);
    tick();
    reset_L = 1'b1;
    tick();
    check("post_rst_valid", 32'(valid_out), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    valid_in = 4'b1111;
    #1;
    check("first_grant", 32'(ready_out), 32'b0001);
    valid_in = 4'b0000;
    #1;
    check("no_req_ready", 32'(ready_out), 32'b0000);

    // 2: single word from requester 0
    set_word(0, 32'hAABBCCDD);
    valid_in = 4'b0001;
    #1;
    check("t2_ready", 32'(ready_out), 32'b0001);
    tick();
    valid_in = 4'b0000;
    #1;
    check("t2_ready_once", 32'(ready_out), 32'b0000);
    check_lane("t2_b0", 8'hAA, 1'b1, 2'd0);
    check("t2_busy", 32'(busy), 32'h1);
    tick(); check_lane("t2_b1", 8'hBB, 1'b1, 2'd0);
    tick(); check_lane("t2_b2", 8'hCC, 1'b1, 2'd0);
    tick(); check_lane("t2_b3", 8'hDD, 1'b1, 2'd0);
    tick(); check_lane("t2_idle", 8'h00, 1'b0, 2'd0);
    check("t2_busy_end", 32'(busy), 32'h0);

    // 3: fresh reset so rr_ptr starts at 3, then all four stream gaplessly
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, words3[i]);
    valid_in = 4'b1111;
    #1;
    check("t3_ready0", 32'(ready_out), 32'b0001);
    tick();
    for (int wi = 0; wi < 4; wi++) begin
      for (int b = 0; b < 4; b++) begin
        w = words3[wi];
        check_lane("t3_byte", w[31-8*b -: 8], 1'b1, 2'(wi));
        if (b == 3) check("t3_ready_next", 32'(ready_out), 32'(4'b0001 << ((wi + 1) % 4)));
        else        check("t3_ready_mid", 32'(ready_out), 32'h0);
        tick();
      end
    end
    check_lane("t3_wrap", 8'h11, 1'b1, 2'd0);
    valid_in = 4'b0000;
    repeat (4) tick();
    check_lane("t3_drain", 8'h00, 1'b0, 2'd0);

    // 4: stall while BB is on the lane, then stall in IDLE
    set_word(0, 32'hAABBCCDD);
    valid_in = 4'b0001;
    #1;
    check("t4_ready", 32'(ready_out), 32'b0001);
    tick();
    valid_in = 4'b0010;
    check_lane("t4_b0", 8'hAA, 1'b1, 2'd0);
    tick(); check_lane("t4_b1", 8'hBB, 1'b1, 2'd0);
    stall = 1'b1;
    #1;
    check("t4_stall_ready", 32'(ready_out), 32'h0);
    tick(); check_lane("t4_hold1", 8'hBB, 1'b1, 2'd0);
    tick(); check_lane("t4_hold2", 8'hBB, 1'b1, 2'd0);
    stall = 1'b0;
    valid_in = 4'b0000;
    tick(); check_lane("t4_b2", 8'hCC, 1'b1, 2'd0);
    tick(); check_lane("t4_b3", 8'hDD, 1'b1, 2'd0);
    stall = 1'b1;
    valid_in = 4'b0001;
    #1;
    check("t4_stall_last_ready", 32'(ready_out), 32'h0);
    tick(); check_lane("t4_stall_hold_dd", 8'hDD, 1'b1, 2'd0);
    stall = 1'b0;
    valid_in = 4'b0000;
    tick(); check_lane("t4_idle", 8'h00, 1'b0, 2'd0);
    stall = 1'b1;
    valid_in = 4'b0001;
    #1;
    check("t4_idle_stall_ready", 32'(ready_out), 32'h0);
    tick();
    check("t4_idle_stall_busy", 32'(busy), 32'h0);
    check("t4_idle_stall_valid", 32'(valid_out), 32'h0);
    stall = 1'b0;
    valid_in = 4'b0000;

    // 5: reset mid-word, then 2 and 0 pending -> 0 wins
    valid_in = 4'b0001;
    tick();
    valid_in = 4'b0000;
    check_lane("t5_b0", 8'hAA, 1'b1, 2'd0);
    tick(); check_lane("t5_b1", 8'hBB, 1'b1, 2'd0);
    reset_L = 1'b0;
    #1;
    check_lane("t5_rst", 8'h00, 1'b0, 2'd0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_gid", 32'(grant_id), 32'h0);
    tick();
    reset_L = 1'b1;
    set_word(2, 32'h01020304);
    valid_in = 4'b0101;
    #1;
    check("t5_ready", 32'(ready_out), 32'b0001);
    tick();
    valid_in = 4'b0000;
    check_lane("t5_new", 8'hAA, 1'b1, 2'd0);
    repeat (4) tick();
    check_lane("t5_drain", 8'h00, 1'b0, 2'd0);

    // 6: serve 2, then 1 and 3 together -> 3 first, then 1
    set_word(1, 32'h5A6B7C8D);
    set_word(3, 32'hF1E2D3C4);
    valid_in = 4'b0100;
    #1;
    check("t6_ready2", 32'(ready_out), 32'b0100);
    tick();
    valid_in = 4'b0000;
    check_lane("t6_r2_b0", 8'h01, 1'b1, 2'd2);
    tick(); tick(); tick();
    check_lane("t6_r2_b3", 8'h04, 1'b1, 2'd2);
    tick();
    check_lane("t6_idle", 8'h00, 1'b0, 2'd0);
    valid_in = 4'b1010;
    #1;
    check("t6_ready3", 32'(ready_out), 32'b1000);
    tick();
    valid_in = 4'b0010;
    check_lane("t6_r3_b0", 8'hF1, 1'b1, 2'd3);
    tick(); tick(); tick();
    check_lane("t6_r3_b3", 8'hC4, 1'b1, 2'd3);
    check("t6_ready1", 32'(ready_out), 32'b0010);
    tick();
    valid_in = 4'b0000;
    check_lane("t6_r1_b0", 8'h5A, 1'b1, 2'd1);
    tick(); check_lane("t6_r1_b1", 8'h6B, 1'b1, 2'd1);
    tick(); tick(); tick();
    check_lane("t6_end", 8'h00, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
